spimaster: RTL
==============

# spimaster

SPI initiator that issues single-byte read and write transactions to the `spiMemory` SPI slave. It generates `sclk_pin`, `cs_pin` and `mosi_pin` from the FPGA clock, samples `miso_pin`, and gives the host a start/busy/done interface. It sits on the host side of the SPI pins, typically in the same FPGA for loopback testing of `spiMemory`.

## Interface
- `CLK_DIV`, default 8: SCLK half-period in `clk` cycles. Must be ≥ 2, and large enough that the slave's input conditioners settle.
- `clk` input 1: FPGA clock. All logic uses the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request a transaction. Sampled only in IDLE.
- `rw` input 1: 1 = read, 0 = write. Captured at start.
- `addr` input 7: memory address. Captured at start.
- `wdata` input 8: write data. Captured at start; ignored for reads.
- `busy` output 1: high from accepted start until done.
- `done` output 1: one-cycle pulse at transaction end.
- `rdata` output 8: last read byte. Updated only on read completion.
- `sclk_pin` output 1: SPI clock. Idles low.
- `cs_pin` output 1: chip select, active-low. Idles high.
- `mosi_pin` output 1: master out, slave in.
- `miso_pin` input 1: master in, slave out.

## Operation
- Frame: 16 SCLK bits, MSB first.
  - Byte 0 is `{addr[6:0], rw}`.
  - Byte 1 is `wdata` for a write, or 8 zeros driven on MOSI for a read.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: `cs_pin`=1, `sclk_pin`=0, `mosi_pin`=0, `busy`=0. When `start`=1:
  - load the 16-bit TX shift register;
  - latch `rw`;
  - set `cs_pin`=0 and `busy`=1;
  - drive `mosi_pin` with TX bit 15;
  - go to SETUP.
- SETUP: hold for CLK_DIV cycles, then go to SHIFT.
- SHIFT: 32 half-phases counted by a 5-bit phase counter and a divide counter.
  - Even phase: `sclk_pin`=0.
  - Odd phase: `sclk_pin`=1.
  - On each high-to-low transition, except after the last bit, shift TX and present the next bit on `mosi_pin`.
  - On the last `clk` cycle of each high phase for bits 8–15, shift `miso_pin` into the RX register.
  - After phase 31, go to HOLD with `sclk_pin`=0.
- HOLD: `cs_pin` stays 0, `mosi_pin`=0, for CLK_DIV cycles. Then `cs_pin`=1; go to GAP.
- GAP: `cs_pin`=1 for CLK_DIV cycles. Then pulse `done`, drop `busy`, and go to IDLE.
  - For a read, `rdata` takes the RX value in the same cycle `done` asserts.
- `start` while `busy` is ignored. Input changes during `busy` are ignored.

## Timing
- Reset values: `cs_pin`=1, `sclk_pin`=0, `mosi_pin`=0, `busy`=0, `done`=0, `rdata`=0, FSM=IDLE. Applied immediately on `rst_n` low.
- Let E0 be the edge at which `start` is accepted. Edges relative to E0:
  - `cs_pin` falls at E0.
  - First SCLK rise at E0+2·CLK_DIV.
  - SCLK rise k (k = 0..15) at E0+(2k+2)·CLK_DIV.
  - Last SCLK fall at E0+33·CLK_DIV.
  - `cs_pin` rises at E0+34·CLK_DIV.
  - `done` is high for the cycle starting at E0+35·CLK_DIV.
  - `busy` falls at the same edge.
- With CLK_DIV=8: `cs_pin` high at 272, `done` at 280.
- MOSI setup before each SCLK rise is CLK_DIV cycles. MISO is sampled CLK_DIV−1 cycles after each rise.
- Back-to-back: if `start` is held high, the next E0 is the cycle after `done`. Minimum `cs_pin` high time is CLK_DIV+1 cycles.
- Reset mid-transaction: pins return to idle immediately, no `done`, `rdata` cleared. The next `start` after release behaves normally.

## Test plan
- Write, CLK_DIV=8, addr=0x15, wdata=0x5A.
  - MOSI at the 16 SCLK rises is 0x2A then 0x5A.
  - `cs_pin` low at 0, high at 272; `done` at 280; `rdata` stays 0.
- Read, addr=0x7F, with a behavioral slave model returning 0xC3 after its falling-edge update.
  - First byte on MOSI is 0xFF; data phase MOSI is 0.
  - `rdata`=0xC3 when `done` asserts.
- Pulse `start` at cycles 0 and 50 → exactly one frame. The second request is ignored; `busy` stays high continuously.
- Assert `rst_n` low at cycle 100 of a write.
  - Outputs go to reset values the same cycle; no `done`.
  - A new write of 0x11 to address 0x01 after release completes correctly.
- Hold `start` high for two transactions.
  - The second `cs_pin` fall is 9 cycles after the first `cs_pin` rise.
  - Exactly two `done` pulses.
- Loopback against `spiMemory`, CLK_DIV=16: write 0xA5 to address 0x2C, then read address 0x2C → `rdata`=0xA5.

Source files
------------

// File: rtl/spimaster.sv
// Single-byte SPI initiator for the spiMemory slave: a 16-bit frame of {addr, rw} then data,
// MSB first, with SCLK idling low and a start/busy/done host handshake.
module spimaster #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk_pin,
  output logic       cs_pin,
  output logic       mosi_pin,
  input  logic       miso_pin
);

  localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

  state_e state_q, state_d;

  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       phase_q, phase_d;
  logic [15:0]      tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             rw_q, rw_d;
  logic             cs_q, cs_d;
  logic             sclk_q, sclk_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             last_div;

  assign last_div = (div_q == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   if (last_div) state_d = SHIFT;
      SHIFT:   if (last_div && phase_q == 5'd31) state_d = HOLD;
      HOLD:    if (last_div) state_d = GAP;
      GAP:     if (last_div) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // MOSI is always tx_q[15]; clearing tx at frame end keeps the pin low outside SHIFT.
  always_comb begin
    div_d   = '0;
    phase_d = phase_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    rw_d    = rw_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (state_q != IDLE) begin
      div_d = last_div ? '0 : div_q + DIV_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          tx_d   = {addr, rw, (rw ? 8'h00 : wdata)};
          rx_d   = '0;
          rw_d   = rw;
          cs_d   = 1'b0;
          busy_d = 1'b1;
        end
      end
      SETUP: begin
        if (last_div) begin
          phase_d = '0;
          sclk_d  = 1'b0;
        end
      end
      SHIFT: begin
        // Data byte is sampled on the final clk cycle of each high phase (bits 8..15).
        if (last_div && phase_q[0] && phase_q >= 5'd17) begin
          rx_d = {rx_q[6:0], miso_pin};
        end
        if (last_div) begin
          if (phase_q == 5'd31) begin
            phase_d = '0;
            sclk_d  = 1'b0;
            tx_d    = '0;
          end else begin
            phase_d = phase_q + 5'd1;
            sclk_d  = ~phase_q[0];
            if (phase_q[0]) begin
              tx_d = {tx_q[14:0], 1'b0};
            end
          end
        end
      end
      HOLD: begin
        if (last_div) cs_d = 1'b1;
      end
      GAP: begin
        if (last_div) begin
          done_d = 1'b1;
          busy_d = 1'b0;
          if (rw_q) rdata_d = rx_q;
        end
      end
      default: begin
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        busy_d = 1'b0;
        tx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      phase_q <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      rw_q    <= 1'b0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      rw_q    <= rw_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign sclk_pin = sclk_q;
  assign cs_pin   = cs_q;
  assign mosi_pin = tx_q[15];

endmodule
